// File: rtl/io_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module  : io_cond_pkg
// Purpose : Shared defaults and types for the pad-input conditioning blocks.
//           DEFAULT_SYNC_STAGES / DEFAULT_DEBOUNCE_CYCLES seed the debouncer
//           parameters; bit_state_e names the two per-bit debounce states.
// Rev     : 1.0  initial release
// ============================================================================
package io_cond_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // SETTLED: synchronised level agrees with the clean level, counter idle.
  // PENDING: synchronised level disagrees, counter running.
  typedef enum logic {
    SETTLED = 1'b0,
    PENDING = 1'b1
  } bit_state_e;

endpackage : io_cond_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module  : debounce_bit
// Purpose : Single-bit synchroniser + debouncer with registered edge pulses.
// Ports   : clk       rising-edge clock
//           rst_n     asynchronous active-low reset
//           ena       enable; low clears and holds the counter
//           raw_i     asynchronous pad input
//           clean_o   debounced level
//           rise_o    one-cycle pulse on clean 0->1
//           fall_o    one-cycle pulse on clean 1->0
//           settled_o synchronised level == clean level and counter idle
// Rev     : 1.0  initial release
// ============================================================================
module debounce_bit
  import io_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic settled_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Stage 0 samples the pad; the last stage is the only one the debouncer sees.
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (ena && (sync_lvl != clean_q)) begin
      if (cnt_q == CNT_LAST) begin
        // Disagreement has lasted DEBOUNCE_CYCLES evaluations: accept it.
        // Counter restarts at 0, which also spaces successive pulses.
        clean_d = sync_lvl;
        rise_d  = sync_lvl;
        fall_d  = ~sync_lvl;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o   = clean_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign settled_o = (sync_lvl == clean_q) && (cnt_q == '0);

endmodule : debounce_bit
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : input_debouncer
// Purpose : WIDTH independent synchronise-and-debounce channels between the
//           raw pad inputs and the select/data mux stage.
// Ports   : clk        rising-edge clock
//           rst_n      asynchronous active-low reset
//           ena        enable; low clears and holds all debounce counters
//           raw_in     asynchronous pad inputs [WIDTH]
//           clean_out  debounced levels [WIDTH]
//           rise_pulse one-cycle 0->1 pulses [WIDTH]
//           fall_pulse one-cycle 1->0 pulses [WIDTH]
//           stable     every channel settled (combinational from flops)
// Rev     : 1.0  initial release
// ============================================================================
module input_debouncer
  import io_cond_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             stable
);

  logic [WIDTH-1:0] settled_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .raw_i     (raw_in[i]),
      .clean_o   (clean_out[i]),
      .rise_o    (rise_pulse[i]),
      .fall_o    (fall_pulse[i]),
      .settled_o (settled_w[i])
    );
  end

  assign stable = &settled_w;

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_input_debouncer
// Purpose : Randomised + directed bench for input_debouncer with a
//           queue-based scoreboard fed by a window-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_input_debouncer;
  import io_cond_pkg::*;

  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena   = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clean_out, rise_pulse, fall_pulse;
  logic         stable;

  int errors = 0;
  int checks = 0;
  int pending_cycles = 0;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         stb;
  } obs_t;

  obs_t sb[$];

  always #5 clk = ~clk;

  input_debouncer #(
    .WIDTH           (W),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .stable     (stable)
  );

  // ---------------- reference model ----------------
  // Synchroniser = pure S-edge delay of raw samples.  A bit is accepted when
  // the last D evaluations were all enabled and all disagreed with clean.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] h_sync[$];
  logic         h_ena[$];
  logic [W-1:0] m_clean;
  logic [W-1:0] cur, nsync, nclean, m_rise, m_fall, busy, hs;
  logic [W-1:0] dropv;
  logic         dropb;
  logic         run_ok;
  obs_t         e;
  bit_state_e   st;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pipe.delete();
        for (int i = 0; i < S; i++) m_pipe.push_back('0);
        h_sync.delete();
        h_ena.delete();
        m_clean = '0;
        sb.delete();
      end else begin
        cur = m_pipe.pop_front();
        m_pipe.push_back(raw_in);
        nsync = m_pipe[0];
        h_sync.push_front(cur);
        h_ena.push_front(ena);
        if (h_sync.size() > D) begin
          dropv = h_sync.pop_back();
          dropb = h_ena.pop_back();
        end
        nclean = m_clean;
        m_rise = '0;
        m_fall = '0;
        busy   = '0;
        for (int b = 0; b < W; b++) begin
          run_ok = (h_sync.size() == D);
          for (int k = 0; k < h_sync.size(); k++) begin
            hs = h_sync[k];
            if (!h_ena[k] || hs[b] == m_clean[b]) run_ok = 1'b0;
          end
          if (run_ok) begin
            nclean[b] = cur[b];
            m_rise[b] = cur[b];
            m_fall[b] = ~cur[b];
          end else if (ena && cur[b] != m_clean[b]) begin
            busy[b] = 1'b1;
          end
          st = busy[b] ? PENDING : SETTLED;
          if (st == PENDING) pending_cycles++;
        end
        m_clean = nclean;
        e.clean = nclean;
        e.rise  = m_rise;
        e.fall  = m_fall;
        e.stb   = ((nsync ^ nclean) == '0) && (busy == '0);
        sb.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  obs_t got, exp_o;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() != 0) begin
        exp_o = sb.pop_front();
        got   = {clean_out, rise_pulse, fall_pulse, stable};
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL scoreboard t=%0t got clean=%h rise=%h fall=%h stable=%b exp clean=%h rise=%h fall=%h stable=%b",
                   $time, got.clean, got.rise, got.fall, got.stb,
                   exp_o.clean, exp_o.rise, exp_o.fall, exp_o.stb);
        end
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, req);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset with raw high, then release
    raw_in = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_clean", 32'(clean_out), 32'h00);
    chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
    chk("rst_stable", 32'(stable), 32'h1);
    #1 rst_n = 1'b1;
    edges(5);
    chk("t1_clean_e5", 32'(clean_out), 32'h00);
    edges(1);
    chk("t1_clean_e6", 32'(clean_out), 32'hFF);
    chk("t1_rise_e6", 32'(rise_pulse), 32'hFF);
    edges(1);
    chk("t1_rise_e7", 32'(rise_pulse), 32'h00);

    // 5. simultaneous falls
    @(negedge clk); raw_in = 8'h00;
    edges(5);
    chk("t5_clean_e5", 32'(clean_out), 32'hFF);
    edges(1);
    chk("t5_clean_e6", 32'(clean_out), 32'h00);
    chk("t5_fall_e6", 32'(fall_pulse), 32'hFF);
    edges(1);
    chk("t5_fall_e7", 32'(fall_pulse), 32'h00);

    // 2. clean step on bit 0
    @(negedge clk); raw_in = 8'h01;
    edges(2);
    for (int k = 3; k <= 5; k++) begin
      edges(1);
      chk("t2_stable_low", 32'(stable), 32'h0);
    end
    edges(1);
    chk("t2_clean_e6", 32'(clean_out), 32'h01);
    chk("t2_rise_e6", 32'(rise_pulse), 32'h01);
    chk("t2_stable_e6", 32'(stable), 32'h1);

    // 3. glitch on bit 3 for 3 cycles
    @(negedge clk); raw_in = 8'h09;
    repeat (3) @(negedge clk);
    raw_in = 8'h01;
    edges(8);
    chk("t3_clean", 32'(clean_out), 32'h01);
    chk("t3_stable", 32'(stable), 32'h1);

    // 4. ena gating on bit 5
    @(negedge clk); ena = 1'b0; raw_in = 8'h21;
    repeat (10) @(negedge clk);
    chk("t4_hold", 32'(clean_out), 32'h01);
    ena = 1'b1;
    edges(3);
    chk("t4_e3", 32'(clean_out), 32'h01);
    edges(1);
    chk("t4_e4", 32'(clean_out), 32'h21);
    edges(4);

    // 6. reset mid-bounce on bit 2
    @(negedge clk); raw_in = 8'h25;
    edges(4);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_clean", 32'(clean_out), 32'h00);
    chk("t6_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
    repeat (2) @(negedge clk);
    raw_in = 8'h00;
    #1 rst_n = 1'b1;
    edges(8);
    chk("t6_after", 32'(clean_out), 32'h00);

    // randomised phase, scoreboard does the checking
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) raw_in[b] = ~raw_in[b];
      if ($urandom_range(0, 40) == 0) ena = ~ena;
      if (c == 700) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
    ena = 1'b1;
    repeat (20) @(negedge clk);

    $display("pending bit-cycles observed: %0d", pending_cycles);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_input_debouncer
`default_nettype wire
